multicycle_controller: RTL

Main control FSM for the multicycle RV32I datapath. It decodes the latched instruction fields and walks every instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath's mux selects, ALU operation and write enables. It also resolves conditional branches from the ALU flags.

---
 rtl/multicycle_controller_pkg.sv | 70 +++++++
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller_alu_decoder.sv | 35 +++
 rtl/multicycle_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: state codes,
// datapath select encodings, ALU operations and opcode constants.
package controller_pkg;

  // State codes (4-bit).
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JALR2    = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;

  // ALU operations.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // ALU operation class handed to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate formats.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Result mux.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMMEXT = 2'b11;

  // ALU source A / B muxes.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Opcodes.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle. The controller uses the master
// modport, the datapath (or a bench) the slave modport.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       cout;
  logic       overflow;
  logic       sign;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, Zero, cout, overflow, sign,
    output ImmSrc, ALUControl, ResultSrc, ALUSrcA, ALUSrcB, AdrSrc,
           IRWrite, PCWrite, RegWrite, MemWrite, illegal, state
  );

  modport slave (
    output op, funct3, funct7b5, Zero, cout, overflow, sign,
    input  ImmSrc, ALUControl, ResultSrc, ALUSrcA, ALUSrcB, AdrSrc,
           IRWrite, PCWrite, RegWrite, MemWrite, illegal, state
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALU operation class plus instruction
// fields to a concrete ALU operation.
module alu_decoder
  import controller_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [3:0] alu_control_o
);

  // SUB only for R-type (op[5]=1); shifts honour funct7b5 for both R and I.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_SLTU;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control_o = ALU_OR;
          default: alu_control_o = ALU_AND;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4
// DECODE   | read regs, ALUOut <= OldPC+imm, dispatch on opcode
// MEMADR   | ALUOut <= A+imm (load/store address)
// MEMREAD  | drive address from ALUOut, read data
// MEMWB    | rd <= Data
// MEMWRITE | write memory at ALUOut
// EXECR    | ALUOut <= A op B
// EXECI    | ALUOut <= A op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare A-B, PC <= ALUOut if taken
// JAL      | PC <= OldPC+imm, ALUOut <= OldPC+4
// JALR     | ALUOut <= A+imm
// JALR2    | PC <= ALUOut, ALUOut <= OldPC+4
// LUI      | rd <= ImmExt
module multicycle_controller
  import controller_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = S_FETCH
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master ctl
);

  logic [3:0] state_q, state_d;
  logic [2:0] imm_src;
  logic [1:0] aluop;
  logic [1:0] result_src;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       illegal_raw;
  logic       taken;
  logic [3:0] alu_control;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // Branch condition from the flags of the A-B subtraction.
  always_comb begin
    taken = 1'b0;
    case (ctl.funct3)
      3'b000:  taken = ctl.Zero;
      3'b001:  taken = !ctl.Zero;
      3'b100:  taken = ctl.sign ^ ctl.overflow;
      3'b101:  taken = !(ctl.sign ^ ctl.overflow);
      3'b110:  taken = !ctl.cout;
      3'b111:  taken = ctl.cout;
      default: taken = 1'b0;
    endcase
  end

  // Next state and Moore-style datapath controls.
  always_comb begin
    state_d     = S_FETCH;
    imm_src     = IMM_I;
    aluop       = ALUOP_ADD;
    result_src  = RES_ALUOUT;
    src_a       = SRCA_PC;
    src_b       = SRCB_WD;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    illegal_raw = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        src_a      = SRCA_PC;
        src_b      = SRCB_FOUR;
        result_src = RES_ALURES;
        pc_write   = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (ctl.op)
          OP_AUIPC: imm_src = IMM_U;
          OP_JAL:   imm_src = IMM_J;
          default:  imm_src = IMM_B;
        endcase
        case (ctl.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default: begin
            illegal_raw = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = SRCA_A;
        src_b   = SRCB_IMM;
        imm_src = (ctl.op == OP_STORE) ? IMM_S : IMM_I;
        state_d = (ctl.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR: begin
        src_a   = SRCA_A;
        src_b   = SRCB_WD;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = SRCA_A;
        src_b   = SRCB_IMM;
        imm_src = IMM_I;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        src_a      = SRCA_A;
        src_b      = SRCB_WD;
        aluop      = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = taken;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        src_a   = SRCA_A;
        src_b   = SRCB_IMM;
        imm_src = IMM_I;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        imm_src    = IMM_U;
        result_src = RES_IMMEXT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop_i       (aluop),
    .funct3_i      (ctl.funct3),
    .funct7b5_i    (ctl.funct7b5),
    .op5_i         (ctl.op[5]),
    .alu_control_o (alu_control)
  );

  // Enables are held off while reset is low, whatever the state.
  assign ctl.ImmSrc     = imm_src;
  assign ctl.ALUControl = alu_control;
  assign ctl.ResultSrc  = result_src;
  assign ctl.ALUSrcA    = src_a;
  assign ctl.ALUSrcB    = src_b;
  assign ctl.AdrSrc     = adr_src;
  assign ctl.IRWrite    = ir_write    & reset;
  assign ctl.PCWrite    = pc_write    & reset;
  assign ctl.RegWrite   = reg_write   & reset;
  assign ctl.MemWrite   = mem_write   & reset;
  assign ctl.illegal    = illegal_raw & reset;
  assign ctl.state      = state_q;

endmodule
